// File: rtl/decrypt_iter_pkg.sv
// Shared constants, FSM encoding and DES permutation/substitution helpers
// used by the iterative decryption engine.
package decrypt_iter_pkg;

    localparam int N_K = 64;
    localparam int N_B = 64;
    localparam int N_R = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Tables use the DES convention: entry n names input bit n, bit 1 being the MSB.
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    // Right-rotate amount per decryption round; undoes the encryption shifts in reverse.
    localparam int ROT_T [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam int SBOX [512] = '{
        14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
        15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
        10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
         7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
         2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
        12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
         4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
        13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [5:0]  six;
        logic [31:0] s;
        logic [31:0] p;
        e = '0;
        for (int i = 0; i < 48; i++) e[6'(47 - i)] = r[5'(32 - E_T[i])];
        e = e ^ k;
        s = '0;
        for (int b = 0; b < 8; b++) begin
            six = e[6'(47 - 6 * b) -: 6];
            s[5'(31 - 4 * b) -: 4] = 4'(SBOX[9'(64 * b + 16 * int'({six[5], six[0]}) + int'(six[4:1]))]);
        end
        p = '0;
        for (int i = 0; i < 32; i++) p[5'(31 - i)] = s[5'(32 - P_T[i])];
        return p;
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
        logic [55:0] d;
        d = {x, x} >> n;
        return d[27:0];
    endfunction

endpackage

// File: rtl/decrypt_iter_if.sv
// Request/acknowledge bus carrying key and ciphertext in, plaintext out.
interface decrypt_iter_if;
    import decrypt_iter_pkg::*;

    logic           req;
    logic           ack;
    logic [N_K-1:0] k;
    logic [N_B-1:0] c;
    logic [N_B-1:0] m;

    modport master (output req, output k, output c, input ack, input m);
    modport slave  (input req, input k, input c, output ack, output m);
endinterface

// File: rtl/decrypt_iter_key_schedule_dec.sv
// One step of the decryption key schedule: rotate both 28-bit halves right,
// then compress with PC2 to form the round subkey.
module key_schedule_dec
    import decrypt_iter_pkg::*;
(
    output logic [55:0] k_out,
    output logic [47:0] rk,
    input  logic [55:0] k_in,
    input  logic [3:0]  i
);

    assign k_out = {rotr28(k_in[55:28], ROT_T[i]), rotr28(k_in[27:0], ROT_T[i])};
    assign rk    = perm_pc2(k_out);

endmodule

// File: rtl/decrypt_iter.sv
// Iterative DES decryptor: one Feistel round per clock over a shared datapath,
// 4-phase req/ack handshake, registered plaintext.
module decrypt_iter
    import decrypt_iter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    decrypt_iter_if.slave bus
);

    localparam logic [3:0] LAST_ROUND = 4'(N_R - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [3:0]  r_ctr;
    logic [31:0] r_l;
    logic [31:0] r_r;
    logic [55:0] r_cd;
    logic [63:0] r_m;
    logic        r_ack;

    logic [55:0] w_cdNext;
    logic [47:0] w_subkey;
    logic [31:0] w_lNext;
    logic [31:0] w_rNext;
    logic [63:0] w_ip;

    // PC1 of the key is already C16D16, so the first round needs no rotation.
    key_schedule_dec u_keySchedule (
        .k_out (w_cdNext),
        .rk    (w_subkey),
        .k_in  (r_cd),
        .i     (r_ctr)
    );

    assign w_ip    = perm_ip(bus.c);
    assign w_lNext = r_r;
    assign w_rNext = r_l ^ feistel(r_r, w_subkey);

    assign bus.ack = r_ack;
    assign bus.m   = r_m;

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (bus.req) w_nextState = RUN;
            RUN:     if (r_ctr == LAST_ROUND) w_nextState = DONE;
            DONE:    if (!bus.req) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ctr   <= '0;
            r_l     <= '0;
            r_r     <= '0;
            r_cd    <= '0;
            r_m     <= '0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    if (bus.req) begin
                        {r_l, r_r} <= w_ip;
                        r_cd       <= perm_pc1(bus.k);
                        r_ctr      <= '0;
                    end
                end
                RUN: begin
                    r_l   <= w_lNext;
                    r_r   <= w_rNext;
                    r_cd  <= w_cdNext;
                    r_ctr <= r_ctr + 4'd1;
                    // Final round: halves swap back before the inverse permutation.
                    if (r_ctr == LAST_ROUND) begin
                        r_m   <= perm_fp({w_rNext, w_lNext});
                        r_ack <= 1'b1;
                        r_ctr <= '0;
                    end
                end
                DONE: begin
                    if (!bus.req) r_ack <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
